// File: rtl/sdrc_bank_req_accept.sv
// Request-accept stage: takes r2b chunks, buffers them in a FIFO, tracks open rows.
// Ports: r2b_* in / b2r_* out, x2b_* head out, precharge_all, fifo_cnt, proto_err. Opt macro: SDRC_REQ_ACCEPT_CHK_EN
module sdrc_bank_req_accept #(
  parameter int APP_RW   = 9,
  parameter int REQ_ID_W = 4,
  parameter int FIFO_AW  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r2b_req,
  input  logic [REQ_ID_W-1:0] r2b_req_id,
  input  logic                r2b_start,
  input  logic                r2b_last,
  input  logic                r2b_wrap,
  input  logic [1:0]          r2b_ba,
  input  logic [11:0]         r2b_raddr,
  input  logic [11:0]         r2b_caddr,
  input  logic [APP_RW-1:0]   r2b_len,
  input  logic                r2b_write,
  output logic                b2r_ack,
  output logic                b2r_arb_ok,
  output logic                x2b_req,
  output logic [REQ_ID_W-1:0] x2b_req_id,
  output logic                x2b_start,
  output logic                x2b_last,
  output logic                x2b_wrap,
  output logic [1:0]          x2b_ba,
  output logic [11:0]         x2b_raddr,
  output logic [11:0]         x2b_caddr,
  output logic [APP_RW-1:0]   x2b_len,
  output logic                x2b_write,
  output logic                x2b_page_hit,
  input  logic                x2b_ack,
  input  logic                precharge_all,
  output logic [FIFO_AW:0]    fifo_cnt,
  output logic                proto_err
);

  typedef struct packed {
    logic [REQ_ID_W-1:0] id;
    logic                start;
    logic                last;
    logic                wrap;
    logic [1:0]          ba;
    logic [11:0]         raddr;
    logic [11:0]         caddr;
    logic [APP_RW-1:0]   len;
    logic                write;
  } chunk_t;

  typedef enum logic {
    BURST_IDLE,
    BURST_ACTIVE
  } burst_e;

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_TWO  = (FIFO_AW+1)'(2);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  chunk_t              mem_q [DEPTH];
  chunk_t              in_c;
  chunk_t              head;
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    cnt_q, cnt_d;
  logic [FIFO_AW:0]    free_d;
  logic                arb_ok_q;
  logic                full, empty, push, pop;
  logic [3:0]          row_open_q;
  logic [11:0]         open_row_q [4];
  burst_e              state_q, state_d;
  logic                in_burst;

  assign in_c = '{id: r2b_req_id, start: r2b_start, last: r2b_last,
                  wrap: r2b_wrap, ba: r2b_ba, raddr: r2b_raddr,
                  caddr: r2b_caddr, len: r2b_len, write: r2b_write};

  // Full uses registered occupancy only: a same-cycle pop never frees a slot.
  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign b2r_ack = r2b_req & ~full;
  assign push    = b2r_ack;
  assign pop     = x2b_ack & ~empty;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  assign free_d = FULL_CNT - cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      arb_ok_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q    <= cnt_d;
      arb_ok_q <= (free_d >= CNT_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_c;
  end

  assign head       = mem_q[rd_ptr_q];
  assign x2b_req    = ~empty;
  assign x2b_req_id = head.id;
  assign x2b_start  = head.start;
  assign x2b_last   = head.last;
  assign x2b_wrap   = head.wrap;
  assign x2b_ba     = head.ba;
  assign x2b_raddr  = head.raddr;
  assign x2b_caddr  = head.caddr;
  assign x2b_len    = head.len;
  assign x2b_write  = head.write;
  assign b2r_arb_ok = arb_ok_q;
  assign fifo_cnt   = cnt_q;

  // precharge_all wins over the row opened by a same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_open_q <= '0;
      for (int i = 0; i < 4; i++) open_row_q[i] <= '0;
    end else if (precharge_all) begin
      row_open_q <= '0;
    end else if (pop) begin
      row_open_q[head.ba] <= 1'b1;
      open_row_q[head.ba] <= head.raddr;
    end
  end

  assign x2b_page_hit = x2b_req & row_open_q[head.ba] &
                        (open_row_q[head.ba] == head.raddr);

  always_ff @(posedge clk) begin
    if (reset) state_q <= BURST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (push) begin
      unique case (state_q)
        BURST_IDLE:   if (r2b_start & ~r2b_last) state_d = BURST_ACTIVE;
        BURST_ACTIVE: if (r2b_last) state_d = BURST_IDLE;
        default:      state_d = BURST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_burst = (state_q == BURST_ACTIVE);
  end

`ifdef SDRC_REQ_ACCEPT_CHK_EN
  logic                err;
  logic                perr_q;
  logic                bwr_q;
  logic [REQ_ID_W-1:0] bid_q;

  assign err = push & ((r2b_start & in_burst) |
                       (~r2b_start & ~in_burst) |
                       (r2b_len == '0) |
                       (in_burst & ((r2b_write != bwr_q) |
                                    (r2b_req_id != bid_q))));

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
      bwr_q  <= 1'b0;
      bid_q  <= '0;
    end else begin
      perr_q <= perr_q | err;
      if (push & r2b_start) begin
        bwr_q <= r2b_write;
        bid_q <= r2b_req_id;
      end
    end
  end

  assign proto_err = perr_q;
`else
  logic unused_in_burst;
  assign unused_in_burst = in_burst;
  assign proto_err       = 1'b0;
`endif

endmodule
